// File: rtl/seg7_scan_reader_pkg.sv
// Shared glyph table, inverse lookup and frame-FSM state type for the
// 7-segment scan reader.
package seg7_pkg;

    // Active-low glyph codes, bit6 = g ... bit0 = a, indexed by hex value
    localparam logic [6:0] SEG7_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        COLLECT,
        PEND
    } frame_state_e;

    // Returns {legal, hex}; any code outside the table is illegal
    function automatic logic [4:0] seg7_to_hex(input logic [6:0] seg);
        logic [4:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG7_GLYPH[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse 7-segment decoder: glyph code to hex digit plus a
// legality flag.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       legal,
    output logic [3:0] hex
);

    always_comb begin
        {legal, hex} = seg7_to_hex(seg_n);
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed active-low 7-segment bus, debounces each glyph,
// decodes it back to hex and hands complete frames out over valid/ready.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_n,
    input  logic [NDIGITS-1:0]     dig_sel_n,
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     digit_ok,
    output logic                   upd_valid,
    input  logic                   upd_ready
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int SW = NDIGITS + 7;

    logic [6:0]           seg_s1_q, seg_s2_q;
    logic [NDIGITS-1:0]   sel_s1_q, sel_s2_q;
    logic [SW-1:0]        prev_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*NDIGITS-1:0] live_val_q, live_val_d;
    logic [NDIGITS-1:0]   live_ok_q, live_ok_d;
    logic [NDIGITS-1:0]   seen_q, seen_d;
    logic [4*NDIGITS-1:0] value_q;
    logic [NDIGITS-1:0]   digit_ok_q;
    logic                 upd_valid_q;
    frame_state_e         state_q;

    logic [SW-1:0]        samp;
    logic [NDIGITS-1:0]   sel_act;
    logic                 same, commit, take;
    logic                 glyph_legal;
    logic [3:0]           glyph_hex;

    seg7_glyph_decode u_decode (
        .seg_n (seg_s2_q),
        .legal (glyph_legal),
        .hex   (glyph_hex)
    );

    always_comb begin
        samp    = {sel_s2_q, seg_s2_q};
        sel_act = ~sel_s2_q;
        same    = (samp == prev_q);
        // Counter saturates, so the strobe fires once per stable period
        commit  = same && (cnt_q == CW'(STABLE_CYCLES - 1));
        take    = commit && $onehot(sel_act);

        if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CW'(STABLE_CYCLES)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        live_val_d = live_val_q;
        live_ok_d  = live_ok_q;
        seen_d     = seen_q;
        for (int d = 0; d < NDIGITS; d++) begin
            if (take && sel_act[d]) begin
                seen_d[d] = 1'b1;
                if (glyph_legal) begin
                    live_val_d[4*d +: 4] = glyph_hex;
                    live_ok_d[d]         = 1'b1;
                end else begin
                    live_ok_d[d]         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            sel_s1_q   <= '1;
            sel_s2_q   <= '1;
            prev_q     <= '1;
            cnt_q      <= '0;
            live_val_q <= '0;
            live_ok_q  <= '0;
        end else begin
            seg_s1_q   <= seg_n;
            seg_s2_q   <= seg_s1_q;
            sel_s1_q   <= dig_sel_n;
            sel_s2_q   <= sel_s1_q;
            prev_q     <= samp;
            cnt_q      <= cnt_d;
            live_val_q <= live_val_d;
            live_ok_q  <= live_ok_d;
        end
    end

    // Frame FSM: snapshot includes a commit landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            upd_valid_q <= 1'b0;
            value_q     <= '0;
            digit_ok_q  <= '0;
            seen_q      <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (&seen_d) begin
                        value_q     <= live_val_d;
                        digit_ok_q  <= live_ok_d;
                        seen_q      <= '0;
                        upd_valid_q <= 1'b1;
                        state_q     <= PEND;
                    end else begin
                        seen_q      <= seen_d;
                    end
                end
                PEND: begin
                    seen_q <= seen_d;
                    if (upd_ready) begin
                        upd_valid_q <= 1'b0;
                        state_q     <= COLLECT;
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    upd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign value     = value_q;
    assign digit_ok  = digit_ok_q;
    assign upd_valid = upd_valid_q;

endmodule
